// File: rtl/gf180mcu_osu_sc_gp9t3v3__ro_meas.sv
// Ring-oscillator frequency meter.
// Enables an external inverter-chain ring oscillator, waits a settling interval, then counts
// rising edges of the oscillator output over a programmable window of reference clocks.
// The result is published with a one-cycle done pulse and a saturation flag.
//
// Ports:
//   clk_i      reference clock, all state updates on its rising edge
//   rn_i       synchronous active-low reset
//   start_i    measurement request, sampled only while idle
//   window_i   measurement window length in clk_i cycles, sampled with start_i
//   ro_in_i    ring-oscillator output, asynchronous to clk_i (f <= f_clk/4)
//   en_ro_o    oscillator enable (drives the NAND stage of the ring)
//   busy_o     high from accepted start until done
//   done_o     one-cycle pulse when count_o/ovf_o are updated
//   count_o    rising edges counted in the last window, saturating
//   ovf_o      last measurement saturated
`timescale 1ns / 1ps

module gf180mcu_osu_sc_gp9t3v3__ro_meas #(
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned WIN_W      = 16,
    parameter int unsigned SETTLE_CYC = 16
) (
    input  logic             clk_i,
    input  logic             rn_i,
    input  logic             start_i,
    input  logic [WIN_W-1:0] window_i,
    input  logic             ro_in_i,
    output logic             en_ro_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o
);

    // Timer must hold both the settle reload and the window reload.
    localparam int unsigned SetW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TmrW = (WIN_W > SetW) ? WIN_W : SetW;

    localparam logic [TmrW-1:0]  SettleLoad = TmrW'(SETTLE_CYC - 1);
    localparam logic [TmrW-1:0]  TmrOne     = 1;
    localparam logic [CNT_W-1:0] CntMax     = '1;
    localparam logic [CNT_W-1:0] CntOne     = 1;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StSettle  = 2'd1;
    localparam logic [1:0] StMeasure = 2'd2;
    localparam logic [1:0] StFinish  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [TmrW-1:0]  timer_q, timer_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    // s1/s2 resolve metastability, s3 delays s2 for edge detection.
    logic s1_q, s2_q, s3_q;
    logic edge_det;

    assign edge_det = s2_q & ~s3_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        count_d = count_q;
        ovf_d   = ovf_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    win_d   = window_i;
                    cnt_d   = '0;
                    flag_d  = 1'b0;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    timer_d = SettleLoad;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (timer_q == '0) begin
                    if (win_q == '0) begin
                        state_d = StFinish;
                    end else begin
                        timer_d = TmrW'(win_q) - TmrOne;
                        state_d = StMeasure;
                    end
                end else begin
                    timer_d = timer_q - TmrOne;
                end
            end
            StMeasure: begin
                // The last window cycle still counts its edge.
                if (edge_det) begin
                    if (cnt_q == CntMax) begin
                        flag_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                if (timer_q == '0) begin
                    state_d = StFinish;
                end else begin
                    timer_d = timer_q - TmrOne;
                end
            end
            StFinish: begin
                count_d = cnt_q;
                ovf_d   = flag_q;
                done_d  = 1'b1;
                en_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rn_i) begin
            state_q <= StIdle;
            timer_q <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            s1_q    <= ro_in_i;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
        end
    end

    assign en_ro_o = en_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__ro_meas.sv
// Bench for the ring-oscillator frequency meter.
// A cycle-indexed model records every sampled ro_in value, decides when runs are accepted and
// when they finish, and counts rising edges over each run's window arithmetically. A compare
// process checks all outputs against it every cycle; directed runs pin literal results.
`timescale 1ns / 1ps

module tb_gf180mcu_osu_sc_gp9t3v3__ro_meas;

    localparam int S      = 4;
    localparam int CntMax = 15;

    logic       clk = 1'b0;
    logic       rn;
    logic       start;
    logic [7:0] window;
    logic       ro_in;
    logic       en_ro, busy, done, ovf;
    logic [3:0] count;

    gf180mcu_osu_sc_gp9t3v3__ro_meas #(
        .CNT_W      (4),
        .WIN_W      (8),
        .SETTLE_CYC (S)
    ) dut (
        .clk_i    (clk),
        .rn_i     (rn),
        .start_i  (start),
        .window_i (window),
        .ro_in_i  (ro_in),
        .en_ro_o  (en_ro),
        .busy_o   (busy),
        .done_o   (done),
        .count_o  (count),
        .ovf_o    (ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Oscillator stand-in: square wave changing on the falling clock edge.
    int ro_period = 2;
    int ro_ph     = 0;
    always @(negedge clk) begin
        ro_ph = (ro_ph + 1) % ro_period;
        ro_in = (ro_ph < ro_period / 2);
    end

    // Model: samp[t] is ro_in as seen at rising edge t. An oscillator rise between samples
    // t-3 and t-2 is credited at edge t (two synchronizer stages plus the detect flop).
    bit samp [0:8191];
    bit m_active = 1'b0;
    int m_a, m_win, m_end;
    int exp_count = 0;
    bit exp_ovf = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;

    function automatic int edges_in_window(input int a, input int w);
        int n = 0;
        for (int t = a + S + 1; t <= a + S + w; t++) begin
            if (samp[t-2] && !samp[t-3]) n++;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        int n;
        cyc = cyc + 1;
        samp[cyc] = ro_in;
        if (!rn) begin
            m_active  = 1'b0;
            exp_count = 0;
            exp_ovf   = 1'b0;
            exp_busy  = 1'b0;
            exp_done  = 1'b0;
            samp[cyc] = 1'b0;
            samp[cyc-1] = 1'b0;
            samp[cyc-2] = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (m_active && cyc == m_end) begin
                n         = edges_in_window(m_a, m_win);
                exp_count = (n > CntMax) ? CntMax : n;
                exp_ovf   = (n > CntMax);
                exp_done  = 1'b1;
                exp_busy  = 1'b0;
                m_active  = 1'b0;
            end else if (!m_active && start) begin
                m_active = 1'b1;
                m_a      = cyc;
                m_win    = int'(window);
                m_end    = cyc + S + m_win + 1;
                exp_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_done", int'(done), int'(exp_done));
            check("cmp_busy", int'(busy), int'(exp_busy));
            check("cmp_en_ro", int'(en_ro), int'(exp_busy));
            check("cmp_count", int'(count), exp_count);
            check("cmp_ovf", int'(ovf), int'(exp_ovf));
        end
    end

    // One measurement; pulse_at > 0 re-pulses start that many cycles after acceptance.
    task automatic run_meas(input int win, input int period, input int pulse_at,
                            output int done_cyc, output int en_cyc, output int cnt,
                            output int ovf_v, output int n_done);
        int a;
        ro_period = period;
        @(negedge clk);
        window = 8'(win);
        start  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        a        = cyc;
        en_cyc   = 0;
        n_done   = 0;
        done_cyc = -1;
        cnt      = -1;
        ovf_v    = -1;
        for (int i = 0; i < 300; i++) begin
            if (en_ro) en_cyc++;
            if (done) begin
                n_done   = 1;
                done_cyc = cyc - a + 1;
                cnt      = int'(count);
                ovf_v    = int'(ovf);
                break;
            end
            start = (pulse_at > 0 && i == pulse_at);
            @(negedge clk);
        end
        start = 1'b0;
        if (n_done == 0) check("done_timeout", 0, 1);
        repeat (4) begin
            @(negedge clk);
            if (done) n_done++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dc, ec, c, o, nd, got, prev;
        rn     = 1'b0;
        start  = 1'b1;
        window = 8'd0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_en_ro", int'(en_ro), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_count", int'(count), 0);
        check("rst_ovf", int'(ovf), 0);
        start = 1'b0;
        rn    = 1'b1;
        repeat (2) @(negedge clk);
        check("rel_busy", int'(busy), 0);
        check("rel_en_ro", int'(en_ro), 0);

        run_meas(64, 8, 0, dc, ec, c, o, nd);
        check("nom_done_cycle", dc, 70);
        check("nom_en_cycles", ec, 69);
        check("nom_count", c, 8);
        check("nom_ovf", o, 0);
        check("nom_done_pulses", nd, 1);

        run_meas(100, 4, 0, dc, ec, c, o, nd);
        check("sat_count", c, 15);
        check("sat_ovf", o, 1);

        run_meas(8, 4, 0, dc, ec, c, o, nd);
        check("post_sat_count", c, 2);
        check("post_sat_ovf", o, 0);

        run_meas(0, 4, 0, dc, ec, c, o, nd);
        check("zero_done_cycle", dc, 6);
        check("zero_count", c, 0);
        check("zero_ovf", o, 0);

        run_meas(64, 8, 30, dc, ec, c, o, nd);
        check("busy_start_done_cycle", dc, 70);
        check("busy_start_count", c, 8);
        check("busy_start_done_pulses", nd, 1);

        // start held high: back-to-back runs with one idle (done) cycle between them
        ro_period = 4;
        @(negedge clk);
        window = 8'd8;
        start  = 1'b1;
        got    = 0;
        prev   = -1;
        for (int i = 0; i < 200 && got < 3; i++) begin
            @(negedge clk);
            if (done) begin
                got++;
                if (prev >= 0) check("b2b_gap", cyc - prev, S + 8 + 2);
                check("b2b_count", int'(count), 2);
                prev = cyc;
                if (got == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b_runs", got, 3);
        repeat (3) @(negedge clk);

        run_meas(64, 8, 0, dc, ec, c, o, nd);
        check("pre_rst_count", c, 8);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rn = 1'b0;
        @(negedge clk);
        rn = 1'b1;
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_en_ro", int'(en_ro), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        nd = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("mid_rst_no_done", nd, 0);

        run_meas(64, 8, 0, dc, ec, c, o, nd);
        check("after_rst_done_cycle", dc, 70);
        check("after_rst_count", c, 8);
        check("after_rst_ovf", o, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gf180mcu_osu_sc_gp9t3v3__ro_meas.md
# gf180mcu_osu_sc_gp9t3v3__ro_meas

Ring-oscillator frequency meter for on-silicon characterization of the 9-track 3.3 V cell set. It enables an external inverter-chain ring oscillator built from the library inverters, then counts the oscillator's rising edges over a programmable window of reference clocks. It reports the count with done/overflow status, so inverter stage delay can be computed as `T_clk·WINDOW / (2·N_stages·COUNT)`. It is the measuring end of the oscillator built from the inverter cells, and runs entirely in the `CLK` domain.

## Interface
- `CNT_W`, default 20: width of the edge counter and `COUNT`.
- `WIN_W`, default 16: width of `WINDOW`.
- `SETTLE_CYC`, default 16: `CLK` cycles between oscillator enable and window start; must be ≥ 1.
- `CLK` input 1: reference clock; all state updates on its rising edge.
- `RN` input 1: reset, synchronous, active-low.
- `START` input 1: request a measurement; sampled only in IDLE.
- `WINDOW` input `WIN_W`: measurement window length in `CLK` cycles; sampled with `START`.
- `RO_IN` input 1: ring-oscillator output, asynchronous to `CLK`; its frequency must be ≤ f_CLK/4.
- `EN_RO` output 1: oscillator enable, driving the NAND stage of the ring.
- `BUSY` output 1: high from accepted `START` until DONE.
- `DONE` output 1: one-cycle pulse when `COUNT` is updated.
- `COUNT` output `CNT_W`: rising edges counted in the last window, saturating.
- `OVF` output 1: the last measurement saturated.

## Operation
- **`RO_IN` path:** passes through a 2-flop synchronizer (`s1`, `s2`) and a delay flop `s3`. A rising edge is detected as `s2 & ~s3`.
- **IDLE:**
  - `EN_RO`=0 and `BUSY`=0.
  - `START`=1 → latch `WINDOW` into `win_q`, clear the edge counter and overflow flag, set `EN_RO`=1 and `BUSY`=1, load the timer with `SETTLE_CYC`-1, go to SETTLE.
- **SETTLE:**
  - The timer decrements each cycle and edges are not counted.
  - At timer=0: if `win_q`=0 go to FINISH; else load the timer with `win_q`-1 and go to MEASURE.
- **MEASURE:**
  - Every cycle with a detected edge increments the counter.
  - At `2^CNT_W-1` the counter holds and the overflow flag sets.
  - At timer=0, that cycle's edge is still counted, then go to FINISH.
- **FINISH** (one cycle):
  - `COUNT` ← counter, `OVF` ← flag, `DONE`=1, `EN_RO`=0, `BUSY`=0.
  - Next state is IDLE.
- **Hold behaviour:** `COUNT` and `OVF` hold their value from the previous FINISH until the next FINISH, and are not cleared by `START`.
- **`START` while `BUSY`:** ignored, with no restart or queueing.
- **`START` in the FINISH cycle:** ignored.
- **`START` held high:** starts a new measurement on the first IDLE cycle.
- **`RN`=0 at any edge, including mid-measurement:**
  - State → IDLE; timer, counter, flag and synchronizer flops cleared.
  - Outputs → `EN_RO`=0, `BUSY`=0, `DONE`=0, `COUNT`=0, `OVF`=0.
  - Reset takes priority over `START`.

## Timing
- **Cycle numbering:** `START` is accepted at edge 0.
- **Edge 0 results:** `EN_RO` and `BUSY` are high after edge 0.
- **SETTLE:** occupies edges 1..`SETTLE_CYC`.
- **MEASURE:** occupies exactly `WINDOW` edges, `SETTLE_CYC`+1 .. `SETTLE_CYC`+`WINDOW`.
- **`DONE`:** high for the one cycle after edge `SETTLE_CYC`+`WINDOW`+1. `COUNT`/`OVF` are valid in that same cycle.
- **`WINDOW`=0:** `DONE` after edge `SETTLE_CYC`+1; `COUNT`=0, `OVF`=0.
- **Edge attribution:** edges are attributed to the cycle in which `s2 & ~s3` is true, i.e. 2–3 `CLK` cycles after the `RO_IN` transition.
- **Accuracy:** the count for a steady oscillator is exact to ±1 edge, and exact when the `RO_IN` period divides `WINDOW`.
- **Earliest restart:** a new measurement can be accepted on the cycle after `DONE`.

## Test plan
- **Reset values:** hold `RN`=0 for 3 cycles with `START`=1 and `RO_IN` toggling → all outputs 0. Release reset with `START`=0 → `BUSY`=0 and `EN_RO`=0.
- **Nominal measurement:** `SETTLE_CYC`=4, `WINDOW`=64, `RO_IN` period 8 `CLK` (any phase) → `EN_RO`=1 for 69 cycles, `DONE` once at cycle 70 after `START`, `COUNT`=8, `OVF`=0.
- **Saturation:** `CNT_W`=4, `WINDOW`=100, `RO_IN` period 4 → `COUNT`=15, `OVF`=1.
  - Next run with `WINDOW`=8 → `COUNT`=2, `OVF`=0.
- **Zero window:** `WINDOW`=0, `SETTLE_CYC`=4 → `DONE` at cycle 6, `COUNT`=0, `OVF`=0.
- **`START` while busy and held high:**
  - Pulse `START` again mid-MEASURE → single `DONE`, count unchanged from the undisturbed run.
  - Hold `START` high → back-to-back measurements, one `DONE` per run, with exactly one IDLE cycle between runs.
- **Reset mid-operation:** `RN`=0 for 1 cycle during MEASURE, after a prior result of 8 → `COUNT`=0, `EN_RO`=0, `BUSY`=0, no `DONE`.
  - A subsequent `START` measures normally.
